// File: rtl/bus_arbiter_if.sv
// Wishbone classic single-beat bus seen from the bus_arbiter.
// Signal suffixes are from the arbiter's point of view: the master modport
// belongs to the arbiter and the slave modport belongs to the SoC bus side.
interface bus_arbiter_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o,
    input  wb_data_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o, wb_sel_o,
    output wb_data_i, wb_ack_i
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port (IF / MEM) arbiter and single-beat Wishbone cycle sequencer.
// MEM has fixed priority over IF, each grant runs one bus cycle, and read
// data comes back through a one-cycle registered response state. A flush
// abandons an in-flight fetch but still lets the bus cycle finish cleanly.
// Optional feature: define BUS_TIMEOUT_EN to abort bus cycles that see no
// ack within TIMEOUT_CYCLES cycles (bus_err_o pulses, zero data returned).
module bus_arbiter
`ifdef BUS_TIMEOUT_EN
#(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
)
`endif
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               if_req_i,
  input  logic [31:0]        if_addr_i,
  output logic [31:0]        if_data_o,
  output logic               if_stall_o,
  input  logic               mem_req_i,
  input  logic               mem_we_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        mem_data_i,
  input  logic [3:0]         mem_sel_i,
  output logic [31:0]        mem_data_o,
  output logic               mem_stall_o,
  output logic               bus_err_o,
  bus_arbiter_if.master      wb
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] IF_BUS  = 3'd1;
  localparam logic [2:0] MEM_BUS = 3'd2;
  localparam logic [2:0] IF_DROP = 3'd3;
  localparam logic [2:0] IF_RSP  = 3'd4;
  localparam logic [2:0] MEM_RSP = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        bus_err_q, bus_err_d;
  logic        timeout;

`ifdef BUS_TIMEOUT_EN
  logic [7:0] cnt_q;

  // Count cycles spent waiting for ack; any non-bus state clears it, so it
  // always starts from zero on the first cycle after a grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else if (state_q == IF_BUS || state_q == MEM_BUS || state_q == IF_DROP) begin
      cnt_q <= cnt_q + 8'd1;
    end else begin
      cnt_q <= 8'd0;
    end
  end

  // Fires in the last allowed cycle, so stb is high for TIMEOUT_CYCLES cycles.
  assign timeout = (cnt_q == TIMEOUT_CYCLES - 8'd1);
`else
  assign timeout = 1'b0;
`endif

  // Next-state and bus/response register update rules.
  always_comb begin
    // NOTE: every _d gets its hold value first so no branch can infer a latch.
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    if_data_d  = if_data_q;
    mem_data_d = mem_data_q;
    bus_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          state_d = MEM_BUS;
          cyc_d   = 1'b1;
          we_d    = mem_we_i;
          addr_d  = mem_addr_i;
          wdata_d = mem_data_i;
          sel_d   = mem_sel_i;
        end else if (if_req_i && !flush_i) begin
          state_d = IF_BUS;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = if_addr_i;
          wdata_d = 32'h0;
          sel_d   = 4'hF;
        end
      end

      IF_BUS: begin
        if (wb.wb_ack_i) begin
          cyc_d = 1'b0;
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            if_data_d = wb.wb_data_i;
            state_d   = IF_RSP;
          end
        end else if (timeout) begin
          // A fetch flushed in the same cycle it times out has nobody to
          // answer, so it skips the response state.
          cyc_d     = 1'b0;
          bus_err_d = 1'b1;
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            if_data_d = 32'h0;
            state_d   = IF_RSP;
          end
        end else if (flush_i) begin
          state_d = IF_DROP;
        end
      end

      IF_DROP: begin
        // The slave still owes an ack; keep the cycle open and discard data.
        if (wb.wb_ack_i) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
        end else if (timeout) begin
          cyc_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end
      end

      MEM_BUS: begin
        // Flush is ignored here: the access is already committed.
        if (wb.wb_ack_i) begin
          cyc_d = 1'b0;
          if (!we_q) begin
            mem_data_d = wb.wb_data_i;
          end
          state_d = MEM_RSP;
        end else if (timeout) begin
          cyc_d      = 1'b0;
          bus_err_d  = 1'b1;
          mem_data_d = 32'h0;
          state_d    = MEM_RSP;
        end
      end

      IF_RSP, MEM_RSP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) begin
      state_q    <= IDLE;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      sel_q      <= 4'h0;
      if_data_q  <= 32'h0;
      mem_data_q <= 32'h0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // cyc and stb always move together for single-beat cycles.
  assign wb.wb_cyc_o  = cyc_q;
  assign wb.wb_stb_o  = cyc_q;
  assign wb.wb_we_o   = we_q;
  assign wb.wb_addr_o = addr_q;
  assign wb.wb_data_o = wdata_q;
  assign wb.wb_sel_o  = sel_q;

  assign if_data_o  = if_data_q;
  assign mem_data_o = mem_data_q;
  assign bus_err_o  = bus_err_q;

  // A port stalls while it requests, except in its own response cycle.
  assign if_stall_o  = if_req_i  && (state_q != IF_RSP);
  assign mem_stall_o = mem_req_i && (state_q != MEM_RSP);

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-requester bus arbiter and cycle sequencer sitting between the CPU pipeline (IF and MEM stages) and the single Wishbone master port to the SoC bus. It grants the bus to the data port over the instruction port, runs one classic single-beat Wishbone cycle per grant, returns read data in a registered response cycle, and drives per-port stall requests to `ctrl`. A pipeline flush discards an in-flight instruction fetch without corrupting the bus protocol.

## Interface
- `TIMEOUT_CYCLES`, 255: bus cycles without `wb_ack_i` before abort; only used with `BUS_TIMEOUT_EN`.
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `flush_i`  in  1  pipeline flush from `ctrl`.
- `if_req_i`  in  1  instruction fetch request; held with address stable until `if_stall_o` drops.
- `if_addr_i`  in  32  fetch physical address, word aligned.
- `if_data_o`  out  32  fetched instruction, registered.
- `if_stall_o`  out  1  stall request for IF.
- `mem_req_i`  in  1  data access request; held stable until `mem_stall_o` drops.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_addr_i`  in  32  data physical address.
- `mem_data_i`  in  32  store data.
- `mem_sel_i`  in  4  byte lane enables.
- `mem_data_o`  out  32  load data, registered.
- `mem_stall_o`  out  1  stall request for MEM.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  Wishbone control, registered.
- `wb_addr_o`, `wb_data_o`  out  32 each  Wishbone address / write data, registered.
- `wb_sel_o`  out  4  Wishbone byte select, registered.
- `wb_data_i`  in  32  Wishbone read data.
- `wb_ack_i`  in  1  Wishbone acknowledge.
- `bus_err_o`  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, IF_BUS, MEM_BUS, IF_DROP, IF_RSP, MEM_RSP.
- IDLE: `mem_req_i` -> MEM_BUS; else `if_req_i` and not `flush_i` -> IF_BUS. MEM has fixed priority; a simultaneous IF request waits.
- On grant edge, latch address/data/sel/we into `wb_*_o`, set `cyc=stb=1`. IF cycles: `we=0`, `sel=4'hF`, `wb_data_o=0`.
- IF_BUS: `wb_ack_i` -> capture `wb_data_i` into `if_data_o`, drop `cyc/stb`, go IF_RSP. `flush_i` without ack -> IF_DROP. `flush_i` with ack -> IDLE, data discarded.
- IF_DROP: keep `cyc/stb` until `wb_ack_i`, discard data, go IDLE.
- MEM_BUS: `wb_ack_i` -> capture `wb_data_i` into `mem_data_o` for loads only; drop `cyc/stb`; go MEM_RSP. `flush_i` ignored, because stores are committed.
- IF_RSP / MEM_RSP: one cycle, then IDLE.
- `if_stall_o = if_req_i && state != IF_RSP`. `mem_stall_o = mem_req_i && state != MEM_RSP`. Both are combinational from state and request.
- Reset (`rst`=0 at edge): state IDLE; all `wb_*_o`=0; `if_data_o`=`mem_data_o`=0; `bus_err_o`=0. This applies even mid-cycle: `cyc` drops the next cycle and no response is produced.

## Timing
- Request seen in IDLE at edge N: `wb_stb_o` is high from cycle N+1.
- Ack sampled at edge M: data registered at M, RSP state during cycle M+1, stall low in cycle M+1, IDLE at M+2.
- Minimum access: 3 cycles with zero-wait ack. Back-to-back requests of the same port use 3 cycles each.
- A MEM request arriving while IF_BUS is active waits for the IF completion; there is no preemption.
- `wb_*_o` stay constant for the whole cycle while `stb`=1.

## Configuration
- `BUS_TIMEOUT_EN` defined: 8-bit counter cleared on grant and incremented each cycle in IF_BUS/MEM_BUS/IF_DROP. When it reaches `TIMEOUT_CYCLES` with no ack: drop `cyc/stb`, pulse `bus_err_o`, load 32'h0 into the port's data register, go to the matching RSP state (IF_DROP goes to IDLE).
- Without `BUS_TIMEOUT_EN`: no counter, cycles wait forever, `bus_err_o` tied 0.

## Test plan
- IF read, addr 0xBFC00000, ack after 2 wait cycles with data 0x3C08BFD0 -> `stb` high 3 cycles, `if_data_o`=0x3C08BFD0, `if_stall_o` low exactly one cycle.
- Simultaneous `if_req_i`/`mem_req_i` (load 0x80000010) in IDLE -> MEM cycle first, `if_stall_o` stays high, then the IF cycle starts the cycle after MEM_RSP.
- Store, sel 4'b0011, data 0x0000BEEF, addr 0x80000004 -> `wb_we_o`=1, `wb_sel_o`=4'b0011, `mem_data_o` unchanged.
- `flush_i` pulse during IF_BUS, ack 3 cycles later with 0xDEADBEEF -> `cyc` held to ack, `if_data_o` unchanged, no IF_RSP, next fetch starts afterwards.
- `rst` low during MEM_BUS -> all outputs 0 after the edge, state IDLE, no `mem_stall_o` release pulse.
- `BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack on load -> `bus_err_o` one-cycle pulse, `mem_data_o`=0, `mem_stall_o` low one cycle.
